// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: control bundle between stack_ctrl and the stack-processor datapath.
//   master (controller): receives opcode/tos_zero, drives every control strobe,
//                        plus err and depth from the occupancy guard.
//   slave  (datapath):   the mirror image.
// Signals:
//   opcode[2:0]   IR opcode field          tos_zero      stack Dout == 0
//   ir_wr, pc_wr, pc_src                   IR load, PC load, PC source (0 PC+1, 1 IR addr)
//   mem_rd, mem_wr, i_or_d                 memory strobes, address source (0 PC, 1 IR addr)
//   stk_push, stk_pop, stk_tos             Stack block strobes
//   a_wr, b_wr                             ALU operand register loads
//   alu_op[1:0]   00 ADD 01 SUB 10 AND 11 NOT
//   din_src       stack Din source (0 MDR, 1 ALU)
//   err           guard trap flag          depth[DEPTH_W-1:0] stack occupancy
interface stack_ctrl_if #(
    parameter int unsigned DEPTH_W = 4
) ();
    logic [2:0]         opcode;
    logic               tos_zero;
    logic               ir_wr;
    logic               pc_wr;
    logic               pc_src;
    logic               mem_rd;
    logic               mem_wr;
    logic               i_or_d;
    logic               stk_push;
    logic               stk_pop;
    logic               stk_tos;
    logic               a_wr;
    logic               b_wr;
    logic [1:0]         alu_op;
    logic               din_src;
    logic               err;
    logic [DEPTH_W-1:0] depth;

    modport master (
        input  opcode, tos_zero,
        output ir_wr, pc_wr, pc_src, mem_rd, mem_wr, i_or_d,
        output stk_push, stk_pop, stk_tos, a_wr, b_wr, alu_op, din_src, err, depth
    );

    modport slave (
        output opcode, tos_zero,
        input  ir_wr, pc_wr, pc_src, mem_rd, mem_wr, i_or_d,
        input  stk_push, stk_pop, stk_tos, a_wr, b_wr, alu_op, din_src, err, depth
    );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: multi-cycle Moore control unit for the stack processor. Sequences fetch,
// decode, stack pops/pushes, ALU operand latching, memory access and jumps, one
// instruction at a time. Drives control strobes only; data stays in the datapath.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; while high every output (depth, err too) is 0
//   bus  stack_ctrl_if.master: opcode/tos_zero in, control strobes, err, depth out
// Build option:
//   STACK_CTRL_GUARD_EN  builds the occupancy counter, the DECODE-time overflow/underflow
//                        check and the TRAP state. Undefined: depth and err are tied to 0.
module stack_ctrl #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DEPTH_W = 4
) (
    input logic          clk,
    input logic          rst,
    stack_ctrl_if.master bus
);

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpSub  = 3'b001;
    localparam logic [2:0] OpAnd  = 3'b010;
    localparam logic [2:0] OpNot  = 3'b011;
    localparam logic [2:0] OpPush = 3'b100;
    localparam logic [2:0] OpPop  = 3'b101;
    localparam logic [2:0] OpJmp  = 3'b110;
    localparam logic [2:0] OpJz   = 3'b111;

    // The occupancy counter must be able to represent DEPTH itself.
    if (DEPTH >= (32'd1 << DEPTH_W)) begin : g_cfg_check
        $error("stack_ctrl: DEPTH does not fit in DEPTH_W bits");
    end

    typedef enum logic [3:0] {
        StFetch, StDecode, StPopA, StLatchA, StPopB, StLatchB, StExec,
        StMemRd, StPushWr, StMemWr, StJump, StTosRd, StJzTest
`ifdef STACK_CTRL_GUARD_EN
        , StTrap
`endif
    } state_e;

    state_e state_q, state_d;
    logic   guard_viol;

    logic ir_wr, pc_wr, pc_src, mem_rd, mem_wr, i_or_d;
    logic stk_push, stk_pop, stk_tos, a_wr, b_wr, din_src;
    logic [1:0] alu_op;

`ifdef STACK_CTRL_GUARD_EN
    logic [DEPTH_W-1:0] depth_q, depth_d;

    always_comb begin
        guard_viol = 1'b0;
        case (bus.opcode)
            OpAdd, OpSub, OpAnd: guard_viol = (depth_q < DEPTH_W'(2));
            OpNot, OpPop, OpJz:  guard_viol = (depth_q == '0);
            OpPush:              guard_viol = (depth_q >= DEPTH_W'(DEPTH));
            default:             guard_viol = 1'b0;
        endcase
    end

    always_comb begin
        depth_d = depth_q;
        if (stk_push) begin
            depth_d = depth_q + 1'b1;
        end else if (stk_pop) begin
            depth_d = depth_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

    assign bus.depth = rst ? '0 : depth_q;
    assign bus.err   = !rst && (state_q == StTrap);
`else
    assign guard_viol = 1'b0;
    assign bus.depth  = '0;
    assign bus.err    = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (bus.opcode)
                    OpPush:  state_d = StMemRd;
                    OpJmp:   state_d = StJump;
                    OpJz:    state_d = StTosRd;
                    default: state_d = StPopA;
                endcase
`ifdef STACK_CTRL_GUARD_EN
                if (guard_viol) state_d = StTrap;
`endif
            end
            StPopA:   state_d = StLatchA;
            StLatchA: begin
                case (bus.opcode)
                    OpNot:   state_d = StExec;
                    OpPop:   state_d = StMemWr;
                    default: state_d = StPopB;
                endcase
            end
            StPopB:   state_d = StLatchB;
            StLatchB: state_d = StExec;
            StExec:   state_d = StFetch;
            StMemRd:  state_d = StPushWr;
            StPushWr: state_d = StFetch;
            StMemWr:  state_d = StFetch;
            StJump:   state_d = StFetch;
            StTosRd:  state_d = StJzTest;
            StJzTest: state_d = StFetch;
`ifdef STACK_CTRL_GUARD_EN
            StTrap:   state_d = StTrap;
`endif
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode; gated by rst so even the FETCH strobes stay low during reset.
    always_comb begin
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        pc_src   = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        i_or_d   = 1'b0;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_tos  = 1'b0;
        a_wr     = 1'b0;
        b_wr     = 1'b0;
        alu_op   = 2'b00;
        din_src  = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem_rd = 1'b1;
                    ir_wr  = 1'b1;
                    pc_wr  = 1'b1;
                end
                StPopA, StPopB: stk_pop = 1'b1;
                StLatchA:       a_wr    = 1'b1;
                StLatchB:       b_wr    = 1'b1;
                StExec: begin
                    stk_push = 1'b1;
                    din_src  = 1'b1;
                    alu_op   = bus.opcode[1:0];
                end
                StMemRd: begin
                    mem_rd = 1'b1;
                    i_or_d = 1'b1;
                end
                StPushWr: stk_push = 1'b1;
                StMemWr: begin
                    mem_wr = 1'b1;
                    i_or_d = 1'b1;
                end
                StJump: begin
                    pc_wr  = 1'b1;
                    pc_src = 1'b1;
                end
                StTosRd: stk_tos = 1'b1;
                StJzTest: begin
                    pc_src = 1'b1;
                    pc_wr  = bus.tos_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.ir_wr    = ir_wr;
    assign bus.pc_wr    = pc_wr;
    assign bus.pc_src   = pc_src;
    assign bus.mem_rd   = mem_rd;
    assign bus.mem_wr   = mem_wr;
    assign bus.i_or_d   = i_or_d;
    assign bus.stk_push = stk_push;
    assign bus.stk_pop  = stk_pop;
    assign bus.stk_tos  = stk_tos;
    assign bus.a_wr     = a_wr;
    assign bus.b_wr     = b_wr;
    assign bus.alu_op   = alu_op;
    assign bus.din_src  = din_src;

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl. Stimulus tasks push the expected per-cycle output word of each
// instruction into a queue; a negedge monitor pops and compares every cycle.
module tb_stack_ctrl;

    localparam int unsigned Depth  = 8;
    localparam int unsigned DepthW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stack_ctrl_if #(.DEPTH_W(DepthW)) bus_if ();

    stack_ctrl #(.DEPTH(Depth), .DEPTH_W(DepthW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct packed {
        logic       ir_wr;
        logic       pc_wr;
        logic       pc_src;
        logic       mem_rd;
        logic       mem_wr;
        logic       i_or_d;
        logic       stk_push;
        logic       stk_pop;
        logic       stk_tos;
        logic       a_wr;
        logic       b_wr;
        logic [1:0] alu_op;
        logic       din_src;
        logic       err;
        logic [3:0] depth;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_depth = 0;   // stack occupancy according to the reference model
    int   instr_idx = 0;
    exp_t mon_e;
    obs_t mon_a;

    function automatic obs_t sample();
        obs_t a;
        a.ir_wr    = bus_if.ir_wr;
        a.pc_wr    = bus_if.pc_wr;
        a.pc_src   = bus_if.pc_src;
        a.mem_rd   = bus_if.mem_rd;
        a.mem_wr   = bus_if.mem_wr;
        a.i_or_d   = bus_if.i_or_d;
        a.stk_push = bus_if.stk_push;
        a.stk_pop  = bus_if.stk_pop;
        a.stk_tos  = bus_if.stk_tos;
        a.a_wr     = bus_if.a_wr;
        a.b_wr     = bus_if.b_wr;
        a.alu_op   = bus_if.alu_op;
        a.din_src  = bus_if.din_src;
        a.err      = bus_if.err;
        a.depth    = bus_if.depth;
        return a;
    endfunction

    // Monitor: one comparison per cycle while expectations are pending.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            mon_a = sample();
            n_tests++;
            if (mon_a !== mon_e.v) begin
                n_fail++;
                $display("FAIL %s: got %b want %b", mon_e.tag, mon_a, mon_e.v);
            end
        end
    end

    function automatic string op_name(input logic [2:0] op);
        case (op)
            3'd0: return "ADD";
            3'd1: return "SUB";
            3'd2: return "AND";
            3'd3: return "NOT";
            3'd4: return "PUSH";
            3'd5: return "POP";
            3'd6: return "JMP";
            default: return "JZ";
        endcase
    endfunction

    // Minimum occupancy an opcode consumes.
    function automatic int need_of(input logic [2:0] op);
        if (op <= 3'd2) return 2;
        if (op == 3'd3 || op == 3'd5 || op == 3'd7) return 1;
        return 0;
    endfunction

    task automatic do_reset(input int n);
        exp_t e;
        rst = 1'b1;
        bus_if.opcode = 3'b100;
        for (int i = 0; i < n; i++) begin
            e.v   = '0;
            e.tag = $sformatf("reset.c%0d", i);
            exp_q.push_back(e);
        end
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_depth = 0;
    endtask

    // Issue one instruction; called 1ns after the edge that enters FETCH.
    // abort_at > 0 cuts the instruction after that many cycles and resets.
    task automatic run_instr(input logic [2:0] op, input logic tz, input int abort_at);
        obs_t seq[$];
        obs_t w;
        exp_t e;
        int   d;
        int   n;
        bit   trap;
        d = model_depth;
        w = '0; w.mem_rd = 1; w.ir_wr = 1; w.pc_wr = 1; seq.push_back(w);
        w = '0; seq.push_back(w);
        trap = 1'b0;
`ifdef STACK_CTRL_GUARD_EN
        trap = (d < need_of(op)) || (op == 3'd4 && d >= int'(Depth));
`endif
        if (trap) begin
            for (int i = 0; i < 3; i++) begin
                w = '0; w.err = 1; seq.push_back(w);
            end
        end else begin
            case (op)
                3'd0, 3'd1, 3'd2, 3'd3, 3'd5: begin
                    w = '0; w.stk_pop = 1; seq.push_back(w);
                    w = '0; w.a_wr = 1; seq.push_back(w);
                    if (op <= 3'd2) begin
                        w = '0; w.stk_pop = 1; seq.push_back(w);
                        w = '0; w.b_wr = 1; seq.push_back(w);
                    end
                    if (op == 3'd5) begin
                        w = '0; w.mem_wr = 1; w.i_or_d = 1; seq.push_back(w);
                    end else begin
                        w = '0; w.stk_push = 1; w.din_src = 1; w.alu_op = op[1:0];
                        seq.push_back(w);
                    end
                end
                3'd4: begin
                    w = '0; w.mem_rd = 1; w.i_or_d = 1; seq.push_back(w);
                    w = '0; w.stk_push = 1; seq.push_back(w);
                end
                3'd6: begin
                    w = '0; w.pc_wr = 1; w.pc_src = 1; seq.push_back(w);
                end
                default: begin
                    w = '0; w.stk_tos = 1; seq.push_back(w);
                    w = '0; w.pc_src = 1; w.pc_wr = tz; seq.push_back(w);
                end
            endcase
        end
        n = (abort_at > 0 && abort_at < seq.size()) ? abort_at : seq.size();
        for (int i = 0; i < n; i++) begin
            e.v = seq[i];
`ifdef STACK_CTRL_GUARD_EN
            e.v.depth = 4'(d);
`else
            e.v.depth = 4'd0;
`endif
            e.tag = $sformatf("i%0d.%s.c%0d", instr_idx, op_name(op), i + 1);
            exp_q.push_back(e);
            if (seq[i].stk_push) d++;
            if (seq[i].stk_pop)  d--;
        end
        bus_if.opcode   = op;
        bus_if.tos_zero = tz;
        repeat (n) @(posedge clk);
        #1;
        model_depth = d;
        instr_idx++;
        if (trap || n < seq.size()) do_reset(2);
    endtask

    initial begin
        logic [2:0] op;
        int         ab;
        rst = 1'b1;
        bus_if.opcode   = 3'b100;
        bus_if.tos_zero = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2);

        // PUSH, PUSH, ADD
        run_instr(3'd4, 1'b0, 0);
        run_instr(3'd4, 1'b0, 0);
        run_instr(3'd0, 1'b0, 0);
        // NOT then POP from depth 1
        run_instr(3'd3, 1'b0, 0);
        run_instr(3'd5, 1'b0, 0);
        // JZ taken / not taken, JMP
        run_instr(3'd4, 1'b0, 0);
        run_instr(3'd7, 1'b1, 0);
        run_instr(3'd7, 1'b0, 0);
        run_instr(3'd6, 1'b1, 0);
        run_instr(3'd5, 1'b0, 0);
`ifdef STACK_CTRL_GUARD_EN
        // Underflow: ADD at depth 1 traps.
        run_instr(3'd4, 1'b0, 0);
        run_instr(3'd0, 1'b0, 0);
        // Overflow: 8 pushes fill the stack, the 9th traps.
        for (int i = 0; i < int'(Depth); i++) run_instr(3'd4, 1'b0, 0);
        run_instr(3'd4, 1'b0, 0);
`else
        // ADD on an empty stack proceeds without a trap.
        run_instr(3'd0, 1'b0, 0);
        do_reset(2);
`endif
        // Reset mid-instruction.
        run_instr(3'd4, 1'b0, 0);
        run_instr(3'd4, 1'b0, 0);
        run_instr(3'd1, 1'b0, 4);

        // Randomized legal instruction stream with occasional aborts.
        for (int k = 0; k < 60; k++) begin
            op = 3'($urandom_range(0, 7));
            if (model_depth < need_of(op)) op = 3'd4;
            if (op == 3'd4 && model_depth >= int'(Depth)) op = 3'd5;
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_instr(op, 1'($urandom_range(0, 1)), ab);
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Multi-cycle control unit for the stack-based processor. It sequences instruction fetch, memory access, the `Stack` block (push/pop/tos) and the ALU operand registers, one instruction at a time. It drives only control strobes; data flows through the existing datapath. An optional guard tracks stack occupancy and traps overflow or underflow.

## Interface
- `DEPTH`, 8: number of stack entries; guard limit.
- `DEPTH_W`, 4: width of the occupancy counter; must hold `DEPTH`.
- `clk`  in  1  clock; everything updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  3  instruction register opcode field; valid from DECODE onward.
- `tos_zero`  in  1  datapath flag; stack `Dout` == 0.
- `ir_wr`, `pc_wr`, `pc_src`  out  1 each  IR load; PC load; PC source (0 = PC+1, 1 = IR address).
- `mem_rd`, `mem_wr`, `i_or_d`  out  1 each  memory read; memory write; address source (0 = PC, 1 = IR address).
- `stk_push`, `stk_pop`, `stk_tos`  out  1 each  `Stack` strobes.
- `a_wr`, `b_wr`  out  1 each  load ALU operand register A or B from stack `Dout`.
- `alu_op`  out  2  00 ADD, 01 SUB, 10 AND, 11 NOT.
- `din_src`  out  1  stack `Din` source (0 = memory data register, 1 = ALU result).
- `err`  out  1  guard trap flag.
- `depth`  out  DEPTH_W  current stack occupancy.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
- Moore FSM. Outputs decode from the state only; any output not listed for a state is 0.
- FETCH: `mem_rd`, `ir_wr`, `pc_wr`; `i_or_d`=0, `pc_src`=0. Next state is DECODE.
- DECODE: no strobes. Dispatch by opcode:
  - ADD/SUB/AND/NOT/POP go to POP_A.
  - PUSH goes to MEM_RD.
  - JMP goes to JUMP.
  - JZ goes to TOS_RD.
- POP_A: `stk_pop`. Next state is LATCH_A.
- LATCH_A: `a_wr`. NOT goes to EXEC; POP goes to MEM_WR; all other opcodes go to POP_B.
- POP_B: `stk_pop`. Next state is LATCH_B.
- LATCH_B: `b_wr`. Next state is EXEC.
- EXEC: `stk_push`, `din_src`=1, `alu_op`=opcode[1:0]. Next state is FETCH.
- MEM_RD: `mem_rd`, `i_or_d`=1. Next state is PUSH_WR.
- PUSH_WR: `stk_push`, `din_src`=0. Next state is FETCH.
- MEM_WR: `mem_wr`, `i_or_d`=1. Next state is FETCH.
- JUMP: `pc_wr`, `pc_src`=1. Next state is FETCH.
- TOS_RD: `stk_tos`. Next state is JZ_TEST.
- JZ_TEST: `pc_src`=1, and `pc_wr`=`tos_zero` (sampled in this state). Next state is FETCH. JZ does not pop.
- TRAP (guard only): all strobes 0, `err`=1. Stays here until `rst`.

## Timing
- Instruction latency in cycles, counted from FETCH through the last state: ADD/SUB/AND 7, NOT 5, POP 5, PUSH 4, JZ 4, JMP 3.
- After `rst` deasserts, the first cycle is FETCH.
- While `rst` is high:
  - state is forced to FETCH;
  - every output is forced to 0, including the FETCH strobes;
  - `depth` is 0 and `err` is 0.
- Asserting `rst` mid-instruction aborts it at the next edge. The stack, PC and memory are not restored.
- `stk_push` and `stk_pop` are never asserted in the same cycle.
- Guard counter:
  - `depth` increments on an edge where `stk_push` is high, and decrements on an edge where `stk_pop` is high.
  - Arithmetic is unsigned DEPTH_W-bit. It never wraps, because the check below prevents it.
- Guard check, evaluated in DECODE:
  - ADD/SUB/AND need `depth` >= 2.
  - NOT, POP and JZ need `depth` >= 1.
  - PUSH needs `depth` < DEPTH.
  - On violation, the next state is TRAP instead of the dispatch target. No stack strobe is issued, so `depth` is unchanged.
- Exact boundaries: `depth`==DEPTH with PUSH traps; `depth`==DEPTH-1 with PUSH is legal and reaches DEPTH.

## Configuration
- `STACK_CTRL_GUARD_EN` defined:
  - the occupancy counter, DECODE check and TRAP state are built;
  - `depth` and `err` behave as above.
- Not defined:
  - no counter and no TRAP state; DECODE always dispatches;
  - `depth` is tied to 0 and `err` is tied to 0;
  - an underflow or overflow is the `Stack` block's behaviour.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `opcode`=100. All outputs are 0. In the cycle after release, `mem_rd`, `ir_wr` and `pc_wr` are 1.
- Run PUSH, PUSH, ADD. Strobe sequence:
  - each PUSH: FETCH, DECODE, MEM_RD, PUSH_WR (`din_src`=0);
  - ADD: `stk_pop`, `a_wr`, `stk_pop`, `b_wr`, then EXEC with `stk_push`, `din_src`=1, `alu_op`=00.
  - Total is 15 cycles; `depth` goes 1, 2, 1.
- Run NOT, then POP, starting at `depth`=1:
  - NOT takes 5 cycles with `alu_op`=11 in EXEC;
  - POP asserts `mem_wr` and `i_or_d`=1 in cycle 5;
  - `depth` ends at 0.
- JZ branching, starting at `depth`=1:
  - `tos_zero`=1 gives `pc_wr`=1 and `pc_src`=1 in cycle 4;
  - `tos_zero`=0 gives `pc_wr`=0;
  - `depth` stays 1 in both cases. JMP always asserts `pc_wr`=`pc_src`=1 in cycle 3.
- Guard (with macro):
  - ADD at `depth`=1 traps after DECODE: `err`=1, no `stk_pop`, held until `rst`;
  - push 8 entries; the 9th PUSH traps with `depth`=8.
- Without macro: ADD at empty stack proceeds to POP_A, and `err` stays 0.
